// File: rtl/max_reduce_stream.sv
// Streaming arg-max / arg-min reducer: each beat of LANES elements is reduced by a
// comparator tree (stage 1), then folded into a per-vector accumulator (stage 2).
module max_reduce_stream #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 16,
  parameter int LANES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  output logic [IDX_W+DATA_W-1:0] out_data,
  output logic                    out_empty,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int LVLS  = $clog2(LANES);
  localparam int NODES = 2 * LANES - 1;

  typedef struct packed {
    logic              any;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
  } cand_t;

  localparam cand_t CAND_EMPTY = '0;

  // The incumbent keeps its place on ties; callers always pass the lower index /
  // earlier beat as the incumbent, which gives the required tie-break everywhere.
  function automatic logic takes_over(cand_t inc, cand_t chal, logic [1:0] m);
    logic gt;
    logic lt;
    if (m[1]) begin
      gt = $signed(chal.val) > $signed(inc.val);
      lt = $signed(chal.val) < $signed(inc.val);
    end else begin
      gt = chal.val > inc.val;
      lt = chal.val < inc.val;
    end
    return chal.any && (!inc.any || (m[0] ? lt : gt));
  endfunction

  function automatic cand_t merge(cand_t inc, cand_t chal, logic [1:0] m);
    return takes_over(inc, chal, m) ? chal : inc;
  endfunction

  // Handshake
  logic stall;
  logic beat_fire;

  // Beat bookkeeping
  logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             first_q, first_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       mode_cur;

  // Stage 1
  logic       s1_valid_q, s1_valid_d;
  cand_t      s1_cand_q, s1_cand_d;
  logic       s1_last_q, s1_last_d;
  logic [1:0] s1_mode_q, s1_mode_d;

  // Stage 2
  cand_t                   acc_q, acc_d;
  cand_t                   merged;
  logic                    out_valid_q, out_valid_d;
  logic                    out_empty_q, out_empty_d;
  logic [IDX_W+DATA_W-1:0] out_data_q, out_data_d;

  // Comparator tree, heap layout: node i has children 2i+1 (lower lanes) and 2i+2.
  cand_t            node [NODES];
  logic [IDX_W-1:0] base_idx;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign beat_fire = in_valid & ~stall;
  assign mode_cur  = first_q ? mode : mode_q;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    base_idx = beat_cnt_q << LVLS;
    for (int n = 0; n < NODES; n++) begin
      node[n] = CAND_EMPTY;
    end
    for (int k = 0; k < LANES; k++) begin
      node[LANES-1+k].any = in_mask[k];
      node[LANES-1+k].idx = base_idx + IDX_W'(k);
      node[LANES-1+k].val = in_data[k*DATA_W +: DATA_W];
    end
    for (int n = LANES - 2; n >= 0; n--) begin
      node[n] = merge(node[2*n+1], node[2*n+2], mode_cur);
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    first_d    = first_q;
    mode_d     = mode_q;
    s1_valid_d = s1_valid_q;
    s1_cand_d  = s1_cand_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;

    if (beat_fire) begin
      beat_cnt_d = in_last ? '0 : beat_cnt_q + IDX_W'(1);
      first_d    = in_last;
      mode_d     = mode_cur;
    end

    if (!stall) begin
      s1_valid_d = in_valid;
      s1_cand_d  = node[0];
      s1_last_d  = in_last;
      s1_mode_d  = mode_cur;
    end
  end

  assign merged = merge(acc_q, s1_cand_q, s1_mode_q);

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_empty_d = out_empty_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Without a stall the output register is either free or emptied this cycle.
    if (!stall && s1_valid_q) begin
      if (s1_last_q) begin
        out_valid_d = 1'b1;
        out_empty_d = ~merged.any;
        out_data_d  = merged.any ? {merged.idx, merged.val} : '0;
        acc_d       = CAND_EMPTY;
      end else begin
        acc_d = merged;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      first_q     <= 1'b1;
      mode_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_cand_q   <= CAND_EMPTY;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= '0;
      acc_q       <= CAND_EMPTY;
      out_valid_q <= 1'b0;
      out_empty_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_cand_q   <= s1_cand_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_empty_q <= out_empty_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_empty = out_empty_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_max_reduce_stream.sv
// Bench for max_reduce_stream (DATA_W=8, IDX_W=16, LANES=4): vector table, random
// vectors against a sequential reference model, and hand-written stall/reset/wrap cases.
module tb_max_reduce_stream;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int LN = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LN*DW-1:0]  in_data;
  logic [LN-1:0]     in_mask;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [1:0]        mode;
  logic [IW+DW-1:0]  out_data;
  logic              out_empty;
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  max_reduce_stream #(.DATA_W(DW), .IDX_W(IW), .LANES(LN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_empty (out_empty),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  val;
    logic        empty;
  } exp_t;

  typedef struct packed {
    logic [1:0]        nbeats;
    logic [2:0][31:0]  data;
    logic [2:0][3:0]   mask;
    logic [2:0][1:0]   md;
    exp_t              exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl [12];

  function automatic logic [31:0] pk(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic exp_t ex(logic [15:0] i, logic [7:0] v, logic e);
    exp_t r;
    r.idx = i;
    r.val = v;
    r.empty = e;
    return r;
  endfunction

  function automatic vec_t mk(int n, logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic [3:0] m0, logic [3:0] m1, logic [3:0] m2,
                              logic [1:0] md0, logic [1:0] md1,
                              logic [15:0] ei, logic [7:0] ev, logic ee);
    vec_t v;
    v.nbeats = 2'(n);
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.mask[0] = m0; v.mask[1] = m1; v.mask[2] = m2;
    v.md[0] = md0;  v.md[1] = md1;  v.md[2] = md1;
    v.exp = ex(ei, ev, ee);
    return v;
  endfunction

  // Walks elements in index order; only a strictly better element replaces the
  // best so far, so the earliest index wins every tie.
  function automatic exp_t model(vec_t v);
    logic        any;
    logic [15:0] bi;
    logic [7:0]  bv;
    logic [7:0]  x;
    logic        win;
    logic [1:0]  m;
    any = 1'b0; bi = '0; bv = '0; m = v.md[0];
    for (int b = 0; b < int'(v.nbeats); b++) begin
      for (int k = 0; k < LN; k++) begin
        if (v.mask[b][k]) begin
          x = v.data[b][k*8 +: 8];
          case (m)
            2'b00:   win = x > bv;
            2'b01:   win = x < bv;
            2'b10:   win = $signed(x) > $signed(bv);
            default: win = $signed(x) < $signed(bv);
          endcase
          if (!any || win) begin
            any = 1'b1;
            bv = x;
            bi = 16'(b * 4 + k);
          end
        end
      end
    end
    return any ? ex(bi, bv, 1'b0) : ex(16'h0, 8'h0, 1'b1);
  endfunction

  // Scoreboard: compare every result as it is handed over downstream.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got 0x%0h expected no result at %0t", out_data, $time);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(out_data), mon_e.empty ? 64'h0 : 64'({mon_e.idx, mon_e.val}));
        check("out_empty", 64'(out_empty), 64'(mon_e.empty));
      end
    end
  end

  task automatic drive_beat(logic [31:0] d, logic [3:0] m, logic l, logic [1:0] md);
    logic rdy;
    int   waits;
    waits = 0;
    in_data = d; in_mask = m; in_last = l; mode = md; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_timeout: in_ready low for %0d cycles, required a transfer", waits);
        break;
      end
    end
  endtask

  task automatic run_vec(vec_t v);
    for (int b = 0; b < int'(v.nbeats); b++) begin
      if (b == int'(v.nbeats) - 1) sb.push_back(v.exp);
      drive_beat(v.data[b], v.mask[b], b == int'(v.nbeats) - 1, v.md[b]);
    end
  endtask

  initial begin
    vec_t rv;
    int   w;
    in_data = '0; in_mask = '0; in_valid = 1'b0; in_last = 1'b0; mode = 2'b00;
    out_ready = 1'b1;
    rst_n = 1'b0;

    tbl[0]  = mk(1, pk(8'h03, 8'h09, 8'hFE, 8'h09), 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 2'b10, 2'b10, 16'd1, 8'h09, 1'b0);
    tbl[1]  = mk(3, pk(8'h00, 8'h01, 8'h02, 8'h03), pk(8'h07, 8'h07, 8'h00, 8'h00), pk(8'h07, 8'h01, 8'h01, 8'h01),
                 4'hF, 4'hF, 4'hF, 2'b00, 2'b00, 16'd4, 8'h07, 1'b0);
    tbl[2]  = mk(1, pk(8'h80, 8'h7F, 8'h01, 8'h00), 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 2'b11, 2'b11, 16'd0, 8'h80, 1'b0);
    tbl[3]  = mk(1, pk(8'h80, 8'h7F, 8'h01, 8'h00), 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 2'b01, 2'b01, 16'd3, 8'h00, 1'b0);
    tbl[4]  = mk(2, pk(8'h11, 8'h22, 8'h33, 8'h44), pk(8'h55, 8'h66, 8'h77, 8'h88), 32'h0,
                 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'd0, 8'h00, 1'b1);
    tbl[5]  = mk(2, pk(8'h01, 8'h02, 8'h03, 8'h04), pk(8'h09, 8'h00, 8'h00, 8'h00), 32'h0,
                 4'hF, 4'hF, 4'h0, 2'b00, 2'b01, 16'd4, 8'h09, 1'b0);
    tbl[6]  = mk(1, pk(8'hC8, 8'h64, 8'h32, 8'hFA), 32'h0, 32'h0, 4'b0111, 4'h0, 4'h0, 2'b00, 2'b00, 16'd0, 8'hC8, 1'b0);
    tbl[7]  = mk(2, pk(8'hFF, 8'hFE, 8'h80, 8'h81), pk(8'h00, 8'h7F, 8'h7F, 8'h7F), 32'h0,
                 4'hF, 4'b0001, 4'h0, 2'b10, 2'b10, 16'd4, 8'h00, 1'b0);
    tbl[8]  = mk(2, pk(8'h05, 8'h09, 8'h09, 8'h09), pk(8'h09, 8'h05, 8'h09, 8'h09), 32'h0,
                 4'hF, 4'hF, 4'h0, 2'b01, 2'b01, 16'd0, 8'h05, 1'b0);
    tbl[9]  = mk(2, pk(8'h00, 8'h00, 8'h00, 8'h00), pk(8'h00, 8'h00, 8'h00, 8'h07), 32'h0,
                 4'h0, 4'b1000, 4'h0, 2'b00, 2'b00, 16'd7, 8'h07, 1'b0);
    tbl[10] = mk(1, pk(8'hFF, 8'h01, 8'h02, 8'h03), 32'h0, 32'h0, 4'b1110, 4'h0, 4'h0, 2'b00, 2'b00, 16'd3, 8'h03, 1'b0);
    tbl[11] = mk(1, pk(8'h7F, 8'h80, 8'h01, 8'h80), 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 2'b11, 2'b11, 16'd1, 8'h80, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_empty", 64'(out_empty), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single-beat latency
    sb.push_back(tbl[0].exp);
    drive_beat(tbl[0].data[0], tbl[0].mask[0], 1'b1, tbl[0].md[0]);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    check("latency_cycle2_valid", 64'(out_valid), 64'h1);
    @(posedge clk);
    #1;

    // Table, back to back
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Random vectors against the model
    for (int i = 0; i < 40; i++) begin
      rv = '0;
      rv.nbeats = 2'(1 + $urandom_range(2));
      for (int b = 0; b < 3; b++) begin
        rv.data[b] = $urandom & 32'h8787_8787;
        rv.mask[b] = 4'($urandom_range(15));
        rv.md[b]   = 2'($urandom_range(3));
      end
      rv.exp = model(rv);
      run_vec(rv);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Downstream stall with the source still pushing
    out_ready = 1'b0;
    fork
      begin
        sb.push_back(ex(16'd3, 8'h04, 1'b0));
        drive_beat(pk(8'h01, 8'h02, 8'h03, 8'h04), 4'hF, 1'b1, 2'b00);
        drive_beat(pk(8'h0A, 8'h14, 8'h1E, 8'h28), 4'hF, 1'b0, 2'b00);
        sb.push_back(ex(16'd4, 8'h32, 1'b0));
        drive_beat(pk(8'h32, 8'h00, 8'h00, 8'h00), 4'hF, 1'b1, 2'b00);
        in_valid = 1'b0;
      end
      begin
        logic [23:0] held;
        int          sw;
        sw = 0;
        do begin
          @(negedge clk);
          sw++;
        end while (!out_valid && sw < 20);
        check("stall_result_seen", 64'(out_valid), 64'h1);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'h0);
          check("stall_out_valid", 64'(out_valid), 64'h1);
          check("stall_out_data_stable", 64'(out_data), 64'(held));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of a vector
    drive_beat(pk(8'hC8, 8'hC9, 8'hCA, 8'hCB), 4'hF, 1'b0, 2'b00);
    drive_beat(pk(8'hFA, 8'h01, 8'h01, 8'h01), 4'hF, 1'b0, 2'b00);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'h0);
      check("midrst_in_ready", 64'(in_ready), 64'h1);
    end
    @(posedge clk);
    #1;
    sb.push_back(ex(16'd3, 8'h08, 1'b0));
    drive_beat(pk(8'h05, 8'h06, 8'h07, 8'h08), 4'hF, 1'b1, 2'b00);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Index wrap: beat 16384 of a vector maps lane k back to index k
    sb.push_back(ex(16'd1, 8'h09, 1'b0));
    drive_beat(pk(8'h00, 8'h00, 8'h05, 8'h00), 4'b0100, 1'b0, 2'b00);
    for (int b = 1; b < 16384; b++) drive_beat(32'h0, 4'h0, 1'b0, 2'b00);
    drive_beat(pk(8'h00, 8'h09, 8'h00, 8'h00), 4'b0010, 1'b1, 2'b00);
    in_valid = 1'b0;

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
